// File: rtl/pwm_multi_driver_if.sv
// Control/status bundle for pwm_multi_driver: run enable, period/duty load handshake and PWM outputs.
// The master side drives configuration; the slave side is the PWM block.
interface pwm_multi_driver_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
);
    logic                      en;
    logic [WIDTH-1:0]          period;
    logic [CHANNELS*WIDTH-1:0] duty;
    logic                      load;
    logic [CHANNELS-1:0]       pwm;
    logic                      period_start;
    logic                      updated;

    modport master (
        output en, period, duty, load,
        input  pwm, period_start, updated
    );

    modport slave (
        input  en, period, duty, load,
        output pwm, period_start, updated
    );
endinterface

// File: rtl/pwm_multi_driver.sv
// Multi-channel PWM with shadowed period/duty that move to the active set only at a period wrap.
// Define PWM_CENTER_ALIGN_EN to build a center-aligned (triangle) counter instead of the sawtooth.
//
// state   | meaning
// ST_IDLE | disabled: count held at 0, outputs low, every edge is a transfer point
// ST_RUN  | counting; shadow-to-active transfer only on the wrap edge
module pwm_multi_driver #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic              clk,
    input  logic              rst,
    pwm_multi_driver_if.slave bus
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t                    state_q, state_d;
    logic [WIDTH-1:0]          count_q, count_d;
    logic [WIDTH-1:0]          period_act_q, period_act_d;
    logic [WIDTH-1:0]          period_sh_q, period_sh_d;
    logic [CHANNELS*WIDTH-1:0] duty_act_q, duty_act_d;
    logic [CHANNELS*WIDTH-1:0] duty_sh_q, duty_sh_d;
    logic                      pending_q, pending_d;
    logic [CHANNELS-1:0]       pwm_q, pwm_d;
    logic                      start_q, start_d;
    logic                      updated_q, updated_d;
    logic [WIDTH-1:0]          cnt_next;
    logic                      cnt_wrap;
    logic                      xfer;
`ifdef PWM_CENTER_ALIGN_EN
    logic                      dir_up_q, dir_up_d;
    logic                      dir_next;
`endif

    // Counter successor while running; cnt_wrap marks the edge that lands on the period start.
    always_comb begin
        cnt_next = count_q + ONE;
        cnt_wrap = 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
        dir_next = dir_up_q;
        if (period_act_q == '0) begin
            cnt_next = '0;
            cnt_wrap = 1'b1;
        end else if (dir_up_q) begin
            if (count_q == period_act_q) begin
                cnt_next = count_q - ONE;
                // With P=1 the peak falls straight back to the valley, which is already the wrap.
                if (period_act_q == ONE) begin
                    cnt_wrap = 1'b1;
                end else begin
                    dir_next = 1'b0;
                end
            end
        end else begin
            cnt_next = count_q - ONE;
            if (count_q == ONE) begin
                cnt_wrap = 1'b1;
                dir_next = 1'b1;
            end
        end
`else
        if (count_q == period_act_q) begin
            cnt_next = '0;
            cnt_wrap = 1'b1;
        end
`endif
    end

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        period_act_d = period_act_q;
        duty_act_d   = duty_act_q;
        period_sh_d  = period_sh_q;
        duty_sh_d    = duty_sh_q;
        pending_d    = pending_q;
        pwm_d        = '0;
        start_d      = 1'b0;
        updated_d    = 1'b0;
        xfer         = 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
        dir_up_d     = dir_up_q;
`endif

        if (bus.load) begin
            period_sh_d = bus.period;
            duty_sh_d   = bus.duty;
            pending_d   = 1'b1;
        end

        if (!bus.en) begin
            state_d = ST_IDLE;
            count_d = '0;
            xfer    = 1'b1;
`ifdef PWM_CENTER_ALIGN_EN
            dir_up_d = 1'b1;
`endif
        end else if (state_q == ST_IDLE) begin
            state_d = ST_RUN;
            count_d = '0;
            xfer    = 1'b1;
`ifdef PWM_CENTER_ALIGN_EN
            dir_up_d = 1'b1;
`endif
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                pwm_d[i] = (count_q < duty_act_q[i*WIDTH +: WIDTH]);
            end
            start_d = (count_q == '0);
            count_d = cnt_next;
            xfer    = cnt_wrap;
`ifdef PWM_CENTER_ALIGN_EN
            dir_up_d = dir_next;
`endif
        end

        // pending_d already folds in a same-cycle load, so the shadow path covers both cases.
        if (xfer && pending_d) begin
            period_act_d = period_sh_d;
            duty_act_d   = duty_sh_d;
            pending_d    = 1'b0;
            updated_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            period_act_q <= '1;
            duty_act_q   <= '0;
            period_sh_q  <= '0;
            duty_sh_q    <= '0;
            pending_q    <= 1'b0;
            pwm_q        <= '0;
            start_q      <= 1'b0;
            updated_q    <= 1'b0;
`ifdef PWM_CENTER_ALIGN_EN
            dir_up_q     <= 1'b1;
`endif
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            period_act_q <= period_act_d;
            duty_act_q   <= duty_act_d;
            period_sh_q  <= period_sh_d;
            duty_sh_q    <= duty_sh_d;
            pending_q    <= pending_d;
            pwm_q        <= pwm_d;
            start_q      <= start_d;
            updated_q    <= updated_d;
`ifdef PWM_CENTER_ALIGN_EN
            dir_up_q     <= dir_up_d;
`endif
        end
    end

    assign bus.pwm          = pwm_q;
    assign bus.period_start = start_q;
    assign bus.updated      = updated_q;
endmodule

// File: tb/tb_pwm_multi_driver.sv
// Scoreboard bench for pwm_multi_driver: a period-position reference model queues the expected
// outputs for every edge and an independent monitor compares them against the DUT.
module tb_pwm_multi_driver;
    localparam int W = 8;
    localparam int C = 4;

    typedef struct packed {
        logic [C-1:0] pwm;
        logic         ps;
        logic         upd;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pwm_multi_driver_if #(.WIDTH(W), .CHANNELS(C)) bus ();
    pwm_multi_driver #(.WIDTH(W), .CHANNELS(C)) dut (.clk(clk), .rst(rst), .bus(bus));

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    // Reference model: position inside the current period plus active/shadow configuration.
    bit           m_run;
    int           m_pos;
    int           m_pact;
    logic [C*W-1:0] m_dact;
    int           m_psh;
    logic [C*W-1:0] m_dsh;
    bit           m_pend;

    int hi_cnt[C];
    int ps_cnt;
    int up_cnt;

    function automatic int plen(input int p);
`ifdef PWM_CENTER_ALIGN_EN
        return (p == 0) ? 1 : 2 * p;
`else
        return p + 1;
`endif
    endfunction

    function automatic logic [C-1:0] wave(input int pos, input int p, input logic [C*W-1:0] d);
        int           cnt;
        logic [C-1:0] r;
        cnt = pos;
`ifdef PWM_CENTER_ALIGN_EN
        if (pos > p) cnt = 2 * p - pos;
`endif
        for (int i = 0; i < C; i++) r[i] = (cnt < int'(d[i*W +: W]));
        return r;
    endfunction

    function automatic void model_step();
        exp_t e;
        bit   xfer;
        e = '0;
        if (rst) begin
            m_run = 0; m_pos = 0; m_pact = (1 << W) - 1; m_dact = '0;
            m_psh = 0; m_dsh = '0; m_pend = 0;
        end else begin
            if (bus.en && m_run) begin
                e.pwm = wave(m_pos, m_pact, m_dact);
                e.ps  = (m_pos == 0);
            end
            xfer = 0;
            if (!bus.en) begin
                m_run = 0; m_pos = 0; xfer = 1;
            end else if (!m_run) begin
                m_run = 1; m_pos = 0; xfer = 1;
            end else if (m_pos == plen(m_pact) - 1) begin
                m_pos = 0; xfer = 1;
            end else begin
                m_pos++;
            end
            if (bus.load) begin
                m_psh = int'(bus.period); m_dsh = bus.duty; m_pend = 1;
            end
            if (xfer && m_pend) begin
                m_pact = m_psh; m_dact = m_dsh; m_pend = 0; e.upd = 1;
            end
        end
        exp_q.push_back(e);
    endfunction

    task automatic cycle();
        model_step();
        @(posedge clk);
        #2;
        cyc++;
    endtask

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic set_cfg(input int p, input int d0, input int d1, input int d2, input int d3);
        bus.period = W'(p);
        bus.duty   = {W'(d3), W'(d2), W'(d1), W'(d0)};
    endtask

    task automatic load_pulse();
        bus.load = 1'b1;
        cycle();
        bus.load = 1'b0;
    endtask

    task automatic wait_pos(input int target);
        bit hit;
        hit = 0;
        for (int k = 0; k < 600 && !hit; k++) begin
            if (m_pos == target) hit = 1;
            else cycle();
        end
        if (!hit) begin
            tests++;
            fails++;
            $display("FAIL wait_pos: position %0d never reached, at %0d", target, m_pos);
        end
    endtask

    task automatic measure(input int n);
        for (int i = 0; i < C; i++) hi_cnt[i] = 0;
        ps_cnt = 0;
        up_cnt = 0;
        repeat (n) begin
            cycle();
            for (int i = 0; i < C; i++) hi_cnt[i] += int'(bus.pwm[i]);
            ps_cnt += int'(bus.period_start);
            up_cnt += int'(bus.updated);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests++;
                if (bus.pwm !== e.pwm || bus.period_start !== e.ps || bus.updated !== e.upd) begin
                    fails++;
                    $display("FAIL scoreboard cyc=%0d pwm got %b exp %b, period_start got %b exp %b, updated got %b exp %b",
                             cyc, bus.pwm, e.pwm, bus.period_start, e.ps, bus.updated, e.upd);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst = 1'b1;
        bus.en = 1'b0;
        bus.load = 1'b0;
        set_cfg(0, 0, 0, 0, 0);
        cycle();
        cycle();
        check("reset_pwm", int'(bus.pwm), 0);
        check("reset_period_start", int'(bus.period_start), 0);
        check("reset_updated", int'(bus.updated), 0);
        rst = 1'b0;

`ifdef PWM_CENTER_ALIGN_EN
        set_cfg(4, 2, 2, 2, 2);
        load_pulse();
        check("center_load_idle_updated", int'(bus.updated), 1);
        bus.en = 1'b1;
        repeat (12) cycle();
        measure(8);
        for (int i = 0; i < C; i++) check("center_high_of_8", hi_cnt[i], 3);
        check("center_period_start_of_8", ps_cnt, 1);
`else
        set_cfg(9, 3, 0, 10, 5);
        load_pulse();
        check("idle_load_updated", int'(bus.updated), 1);
        bus.en = 1'b1;
        repeat (25) cycle();
        measure(10);
        check("ch0_high_of_10", hi_cnt[0], 3);
        check("ch1_high_of_10", hi_cnt[1], 0);
        check("ch2_high_of_10", hi_cnt[2], 10);
        check("ch3_high_of_10", hi_cnt[3], 5);
        check("period_start_of_10", ps_cnt, 1);

        wait_pos(4);
        set_cfg(9, 7, 0, 10, 5);
        load_pulse();
        measure(10);
        check("midperiod_updated_once", up_cnt, 1);
        measure(10);
        check("midperiod_new_duty", hi_cnt[0], 7);

        wait_pos(1);
        set_cfg(9, 2, 0, 10, 5);
        load_pulse();
        repeat (2) cycle();
        set_cfg(9, 8, 0, 10, 5);
        load_pulse();
        measure(10);
        check("double_load_updated_once", up_cnt, 1);
        measure(10);
        check("double_load_last_wins", hi_cnt[0], 8);

        wait_pos(9);
        set_cfg(9, 4, 0, 10, 5);
        load_pulse();
        check("wrap_load_updated", int'(bus.updated), 1);
        measure(10);
        check("wrap_load_no_second_update", up_cnt, 0);
        check("wrap_load_duty", hi_cnt[0], 4);

        bus.en = 1'b0;
        repeat (2) cycle();
        set_cfg(9, 6, 0, 10, 5);
        load_pulse();
        check("disabled_load_updated", int'(bus.updated), 1);
        check("disabled_pwm_low", int'(bus.pwm), 0);
        bus.en = 1'b1;
        cycle();
        check("reenable_no_start_yet", int'(bus.period_start), 0);
        cycle();
        check("reenable_first_start", int'(bus.period_start), 1);
        check("reenable_ch0_high", int'(bus.pwm[0]), 1);
`endif

        wait_pos(3);
        set_cfg(9, 1, 1, 1, 1);
        load_pulse();
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("rst_pwm_low", int'(bus.pwm), 0);
        check("rst_period_start_low", int'(bus.period_start), 0);
        check("rst_updated_low", int'(bus.updated), 0);
        measure(20);
        check("rst_pending_discarded", up_cnt, 0);
        check("rst_duty_zero", hi_cnt[0], 0);

        bus.en = 1'b1;
        for (int n = 0; n < 2500; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            if (bus.en) begin
                if ($urandom_range(0, 59) == 0) bus.en = 1'b0;
            end else if ($urandom_range(0, 7) == 0) begin
                bus.en = 1'b1;
            end
            bus.load   = ($urandom_range(0, 11) == 0);
            bus.period = W'($urandom_range(0, 12));
            for (int i = 0; i < C; i++) bus.duty[i*W +: W] = W'($urandom_range(0, 14));
            cycle();
        end
        rst = 1'b0;
        bus.load = 1'b0;
        repeat (3) cycle();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
